// File: rtl/vic20_io_pkg.sv
// Shared definitions for the VIC-20 host I/O blocks.
//   upl_state_t      : control FSM states of the PRG upload path
//   PTR_BASE_DEFAULT : address of the TXTTAB low byte in zero page
//   UNDERRUN_BYTE    : byte sent when the host outruns the memory fetch
//   PAD_BYTE         : byte sent once the stream has ended
//   stream_len()     : PRG image length (2-byte header + payload)
package vic20_io_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PTR0,
        PTR1,
        PTR2,
        PTR3,
        HDR0,
        HDR1,
        FETCH,
        WAIT_SLOT,
        DONE
    } upl_state_t;

    localparam logic [15:0] PTR_BASE_DEFAULT = 16'h002B;
    localparam logic [7:0]  UNDERRUN_BYTE    = 8'hFF;
    localparam logic [7:0]  PAD_BYTE         = 8'h00;

    // The payload is the bytes from start up to (but excluding) end, walking
    // a 16-bit address that wraps. The modular difference therefore gives the
    // payload size, including a program that straddles $FFFF, and collapses
    // to zero when start equals end.
    function automatic logic [16:0] stream_len(input logic [15:0] start_addr,
                                               input logic [15:0] end_addr);
        logic [15:0] diff;
        diff = end_addr - start_addr;
        return {1'b0, diff} + 17'd2;
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// SPI slave transmitter for the upload stream (mode 0, MSB first).
//   clk_sys, reset_n : system clock, synchronous active-low reset
//   spi_sck, spi_ss  : asynchronous host clock and active-low select
//   spi_do           : MISO, driven 1 while deselected
//   hold_full/data   : parent's holding register and its full flag
//   stream_end       : parent has no more bytes; empty loads become padding
//   take             : one-cycle pulse, holding register consumed
//   underrun_pulse   : one-cycle pulse, a byte was needed but none was ready
//   live             : a real stream byte is still waiting to be shifted out
module spi_tx_shifter
    import vic20_io_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       spi_sck,
    input  logic       spi_ss,
    output logic       spi_do,
    input  logic       hold_full,
    input  logic [7:0] hold_data,
    input  logic       stream_end,
    output logic       take,
    output logic       underrun_pulse,
    output logic       live
);

    logic [2:0] sck_sync_reg;
    logic [2:0] ss_sync_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic       fresh_reg;      // loaded byte whose first bit is not yet sampled
    logic       live_reg;

    logic       sck_rise;
    logic       sck_fall;
    logic       ss_active;
    logic       ss_fall;
    logic       load;
    logic [7:0] load_byte;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sck_sync_reg <= 3'b000;
            ss_sync_reg  <= 3'b111;
        end else begin
            sck_sync_reg <= {sck_sync_reg[1:0], spi_sck};
            ss_sync_reg  <= {ss_sync_reg[1:0], spi_ss};
        end
    end

    assign sck_rise  = sck_sync_reg[1] & ~sck_sync_reg[2];
    assign sck_fall  = ~sck_sync_reg[1] & sck_sync_reg[2];
    assign ss_active = ~ss_sync_reg[1];
    assign ss_fall   = ~ss_sync_reg[1] & ss_sync_reg[2];

    // A byte is loaded when select asserts (unless an untouched byte is
    // already waiting) and on the falling edge that ends each 8-bit frame,
    // so bit 7 is on the wire before the host's first rising edge.
    assign load = ss_active &
                  (ss_fall ? ~fresh_reg : (sck_fall && (bit_cnt_reg == 3'd0)));

    always_comb begin
        load_byte = UNDERRUN_BYTE;
        if (hold_full) begin
            load_byte = hold_data;
        end else if (stream_end) begin
            load_byte = PAD_BYTE;
        end
    end

    assign take           = load & hold_full;
    assign underrun_pulse = load & ~hold_full & ~stream_end;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'hFF;
            fresh_reg   <= 1'b0;
            live_reg    <= 1'b0;
        end else if (!ss_active) begin
            bit_cnt_reg <= 3'd0;
            // Keep only an intact real byte; a partly shifted byte is
            // dropped, and stale padding must not survive the gap.
            if (!(fresh_reg && live_reg)) begin
                fresh_reg <= 1'b0;
                live_reg  <= 1'b0;
            end
        end else begin
            if (load) begin
                shift_reg <= load_byte;
                fresh_reg <= 1'b1;
                live_reg  <= hold_full;
            end else if (sck_fall) begin
                shift_reg <= {shift_reg[6:0], 1'b0};
            end
            if (sck_rise) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                fresh_reg   <= 1'b0;
                if (bit_cnt_reg == 3'd7) begin
                    live_reg <= 1'b0;
                end
            end
        end
    end

    assign spi_do = ss_active ? shift_reg[7] : 1'b1;
    assign live   = live_reg;

endmodule

// File: rtl/prg_upload.sv
// Streams the BASIC program out of VIC-20 RAM as a PRG image over SPI.
//   clk_sys, reset_n : system clock, synchronous active-low reset
//   start            : one-cycle pulse starting an upload (ignored when busy)
//   clkref           : memory slot strobe, reads are issued only when high
//   mem_addr/mem_rd  : read port, mem_rd held until mem_ack
//   mem_ack/mem_din  : read completion with data in the same cycle
//   spi_sck/ss/do    : host SPI channel (asynchronous inputs)
//   busy             : upload in progress until the last bit is shifted out
//   upload_len       : total stream length including the 2-byte header
//   ptr_ok           : pointers captured, upload_len valid
//   underrun         : sticky, host clocked a byte before it was ready
module prg_upload
    import vic20_io_pkg::*;
#(
    parameter logic [15:0] PTR_BASE = PTR_BASE_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        clkref,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_din,
    input  logic        spi_sck,
    input  logic        spi_ss,
    output logic        spi_do,
    output logic        busy,
    output logic [16:0] upload_len,
    output logic        ptr_ok,
    output logic        underrun
);

    upl_state_t  state_reg;
    upl_state_t  state_next;

    logic [7:0]  start_lo_reg;
    logic [7:0]  start_hi_reg;
    logic [7:0]  end_lo_reg;
    logic [7:0]  end_hi_reg;
    logic [15:0] cur_addr_reg;
    logic [7:0]  hold_reg;
    logic        full_reg;
    logic        rd_pend_reg;
    logic [16:0] upload_len_reg;
    logic        ptr_ok_reg;
    logic        underrun_reg;

    logic        rd_phase;
    logic        ack;
    logic        at_end;
    logic        stream_end;
    logic        take;
    logic        underrun_pulse;
    logic        live;

    assign at_end = (cur_addr_reg == {end_hi_reg, end_lo_reg});
    assign ack    = mem_ack & rd_phase;

    // State register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (start) state_next = PTR0;
            PTR0:      if (ack) state_next = PTR1;
            PTR1:      if (ack) state_next = PTR2;
            PTR2:      if (ack) state_next = PTR3;
            PTR3:      if (ack) state_next = HDR0;
            HDR0:      if (!full_reg) state_next = HDR1;
            HDR1:      if (!full_reg) state_next = FETCH;
            FETCH: begin
                if (at_end) begin
                    state_next = DONE;
                end else if (!full_reg) begin
                    state_next = WAIT_SLOT;
                end
            end
            WAIT_SLOT: if (ack) state_next = FETCH;
            DONE:      if (!full_reg && !live) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output logic. The read request appears in a clkref cycle and is then
    // held by rd_pend_reg until acknowledged, whatever clkref does.
    always_comb begin
        rd_phase   = 1'b0;
        mem_addr   = 16'h0000;
        busy       = (state_reg != IDLE);
        stream_end = (state_reg == IDLE) || (state_reg == DONE) ||
                     ((state_reg == FETCH) && at_end);
        case (state_reg)
            PTR0:      begin rd_phase = 1'b1; mem_addr = PTR_BASE;         end
            PTR1:      begin rd_phase = 1'b1; mem_addr = PTR_BASE + 16'd1; end
            PTR2:      begin rd_phase = 1'b1; mem_addr = PTR_BASE + 16'd2; end
            PTR3:      begin rd_phase = 1'b1; mem_addr = PTR_BASE + 16'd3; end
            WAIT_SLOT: begin rd_phase = 1'b1; mem_addr = cur_addr_reg;     end
            default:   begin rd_phase = 1'b0; mem_addr = 16'h0000;         end
        endcase
        mem_rd = rd_phase & (clkref | rd_pend_reg);
    end

    // Datapath. The FSM only fills the holding register while it is empty
    // and the shifter only takes it while full, so set and clear of
    // full_reg never coincide.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            start_lo_reg   <= 8'h00;
            start_hi_reg   <= 8'h00;
            end_lo_reg     <= 8'h00;
            end_hi_reg     <= 8'h00;
            cur_addr_reg   <= 16'h0000;
            hold_reg       <= 8'h00;
            full_reg       <= 1'b0;
            rd_pend_reg    <= 1'b0;
            upload_len_reg <= 17'd0;
            ptr_ok_reg     <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            rd_pend_reg <= mem_rd & ~mem_ack;

            if (take) begin
                full_reg <= 1'b0;
            end

            if ((state_reg == IDLE) && start) begin
                underrun_reg <= 1'b0;
            end else if (underrun_pulse) begin
                underrun_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        ptr_ok_reg     <= 1'b0;
                        upload_len_reg <= 17'd0;
                    end
                end
                PTR0: if (ack) start_lo_reg <= mem_din;
                PTR1: if (ack) start_hi_reg <= mem_din;
                PTR2: if (ack) end_lo_reg   <= mem_din;
                PTR3: begin
                    if (ack) begin
                        end_hi_reg     <= mem_din;
                        upload_len_reg <= stream_len({start_hi_reg, start_lo_reg},
                                                     {mem_din, end_lo_reg});
                        ptr_ok_reg     <= 1'b1;
                        cur_addr_reg   <= {start_hi_reg, start_lo_reg};
                    end
                end
                HDR0: begin
                    if (!full_reg) begin
                        hold_reg <= start_lo_reg;
                        full_reg <= 1'b1;
                    end
                end
                HDR1: begin
                    if (!full_reg) begin
                        hold_reg <= start_hi_reg;
                        full_reg <= 1'b1;
                    end
                end
                WAIT_SLOT: begin
                    if (ack) begin
                        hold_reg     <= mem_din;
                        full_reg     <= 1'b1;
                        cur_addr_reg <= cur_addr_reg + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    spi_tx_shifter u_shifter (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .spi_sck        (spi_sck),
        .spi_ss         (spi_ss),
        .spi_do         (spi_do),
        .hold_full      (full_reg),
        .hold_data      (hold_reg),
        .stream_end     (stream_end),
        .take           (take),
        .underrun_pulse (underrun_pulse),
        .live           (live)
    );

    assign upload_len = upload_len_reg;
    assign ptr_ok     = ptr_ok_reg;
    assign underrun   = underrun_reg;

endmodule

// File: tb/tb_prg_upload.sv
// Directed bench for prg_upload: memory model with slot strobe and
// programmable ack delay, SPI mode-0 host, immediate-assertion checks.
module tb_prg_upload;
    import vic20_io_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        start;
    logic        clkref;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [7:0]  mem_din;
    logic        spi_sck;
    logic        spi_ss;
    logic        spi_do;
    logic        busy;
    logic [16:0] upload_len;
    logic        ptr_ok;
    logic        underrun;

    int          tests_run = 0;
    int          fails     = 0;
    int          ack_delay = 2;
    logic [7:0]  mem [0:65535];

    always #5 clk_sys = ~clk_sys;

    prg_upload dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .start      (start),
        .clkref     (clkref),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ack    (mem_ack),
        .mem_din    (mem_din),
        .spi_sck    (spi_sck),
        .spi_ss     (spi_ss),
        .spi_do     (spi_do),
        .busy       (busy),
        .upload_len (upload_len),
        .ptr_ok     (ptr_ok),
        .underrun   (underrun)
    );

    // Memory port: clkref high one cycle in three; a request seen for
    // ack_delay cycles is answered with a one-cycle ack plus data.
    initial begin
        int wait_cnt;
        int phase;
        wait_cnt = 0;
        phase    = 0;
        clkref   = 1'b0;
        mem_ack  = 1'b0;
        mem_din  = 8'h00;
        forever begin
            @(negedge clk_sys);
            phase  = (phase + 1) % 3;
            clkref = (phase == 0);
            #1;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_rd) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    mem_din  = mem[mem_addr];
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Host shifts n bits, sampling spi_do just before each rising edge.
    task automatic spi_bits(input int n, output logic [7:0] b);
        b = 8'h00;
        @(negedge clk_sys);
        for (int i = 0; i < n; i++) begin
            #40;
            b = {b[6:0], spi_do};
            spi_sck = 1'b1;
            #40;
            spi_sck = 1'b0;
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        spi_bits(8, b);
        $display("[TB] %s: host received %02h", tag, b);
        check(tag, 32'(b), 32'(exp));
    endtask

    task automatic pulse_start();
        @(negedge clk_sys);
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
    endtask

    task automatic ss_set(input logic level);
        spi_ss = level;
        repeat (8) @(negedge clk_sys);
    endtask

    task automatic set_ptrs(input logic [15:0] s, input logic [15:0] e);
        mem[16'h002B] = s[7:0];
        mem[16'h002C] = s[15:8];
        mem[16'h002D] = e[7:0];
        mem[16'h002E] = e[15:8];
    endtask

    task automatic wait_ptr_ok(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys);
            if (ptr_ok) break;
        end
        check(tag, 32'(ptr_ok), 32'd1);
        repeat (10) @(negedge clk_sys);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            if (!busy) break;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_rd"},   32'(mem_rd),     32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr),   32'd0);
        check({tag, "_spi_do"},   32'(spi_do),     32'd1);
        check({tag, "_busy"},     32'(busy),       32'd0);
        check({tag, "_ptr_ok"},   32'(ptr_ok),     32'd0);
        check({tag, "_underrun"}, 32'(underrun),   32'd0);
        check({tag, "_len"},      32'(upload_len), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] last;
        logic       seen;

        reset_n = 1'b0;
        start   = 1'b0;
        spi_sck = 1'b0;
        spi_ss  = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1001] = 8'hAA;
        mem[16'h1002] = 8'hBB;
        mem[16'h1003] = 8'hCC;
        mem[16'h1004] = 8'hDD;
        mem[16'hFFFE] = 8'h11;
        mem[16'hFFFF] = 8'h22;
        mem[16'h0000] = 8'h33;

        // Reset state
        repeat (4) @(negedge clk_sys);
        check_reset_values("rst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Normal program $1001..$1005
        set_ptrs(16'h1001, 16'h1005);
        ack_delay = 2;
        pulse_start();
        check("t1_busy_hi", 32'(busy), 32'd1);
        wait_ptr_ok("t1_ptr_ok");
        check("t1_len", 32'(upload_len), 32'd6);
        pulse_start();
        check("t1_start_ignored", 32'(ptr_ok), 32'd1);
        ss_set(1'b0);
        expect_byte("t1_b0", 8'h01);
        expect_byte("t1_b1", 8'h10);
        expect_byte("t1_b2", 8'hAA);
        expect_byte("t1_b3", 8'hBB);
        expect_byte("t1_b4", 8'hCC);
        check("t1_busy_mid", 32'(busy), 32'd1);
        expect_byte("t1_b5", 8'hDD);
        wait_idle("t1_busy_lo");
        check("t1_underrun", 32'(underrun), 32'd0);
        ss_set(1'b1);

        // Empty program: header then padding
        set_ptrs(16'h1001, 16'h1001);
        pulse_start();
        wait_ptr_ok("t2_ptr_ok");
        check("t2_len", 32'(upload_len), 32'd2);
        ss_set(1'b0);
        expect_byte("t2_b0", 8'h01);
        expect_byte("t2_b1", 8'h10);
        wait_idle("t2_busy_lo");
        expect_byte("t2_pad", 8'h00);
        ss_set(1'b1);

        // Address wrap $FFFE -> $0001
        set_ptrs(16'hFFFE, 16'h0001);
        pulse_start();
        wait_ptr_ok("t3_ptr_ok");
        check("t3_len", 32'(upload_len), 32'd5);
        ss_set(1'b0);
        expect_byte("t3_b0", 8'hFE);
        expect_byte("t3_b1", 8'hFF);
        expect_byte("t3_b2", 8'h11);
        expect_byte("t3_b3", 8'h22);
        expect_byte("t3_b4", 8'h33);
        wait_idle("t3_busy_lo");
        ss_set(1'b1);

        // Slow memory, host clocking immediately: underrun
        set_ptrs(16'h1001, 16'h1005);
        ack_delay = 40;
        pulse_start();
        ss_set(1'b0);
        expect_byte("t4_first_ff", 8'hFF);
        check("t4_underrun", 32'(underrun), 32'd1);
        last = 8'h00;
        for (int k = 0; k < 14; k++) begin
            spi_bits(8, b);
            $display("[TB] t4_drain: host received %02h", b);
            last = b;
            if (!busy) break;
        end
        check("t4_busy_lo", 32'(busy), 32'd0);
        check("t4_last", 32'(last), 32'h0DD);
        ss_set(1'b1);
        ack_delay = 1;
        pulse_start();
        check("t4_underrun_cleared", 32'(underrun), 32'd0);

        // Select dropped after 3 bits: next byte starts at bit 7
        wait_ptr_ok("t5_ptr_ok");
        ss_set(1'b0);
        spi_bits(3, b);
        ss_set(1'b1);
        ss_set(1'b0);
        expect_byte("t5_b1", 8'h10);
        expect_byte("t5_b2", 8'hAA);
        expect_byte("t5_b3", 8'hBB);
        expect_byte("t5_b4", 8'hCC);
        expect_byte("t5_b5", 8'hDD);
        wait_idle("t5_busy_lo");
        ss_set(1'b1);

        // Reset while a payload read is outstanding
        ack_delay = 200;
        pulse_start();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys);
            if (ptr_ok) break;
        end
        ack_delay = 200;
        ss_set(1'b0);
        expect_byte("t6_b0", 8'h01);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            #2;
            if (mem_rd && (mem_addr == 16'h1001)) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_wait_slot", 32'(seen), 32'd1);
        spi_ss  = 1'b1;
        reset_n = 1'b0;
        @(negedge clk_sys);
        #2;
        check_reset_values("t6_rst");
        reset_n   = 1'b1;
        ack_delay = 1;
        repeat (4) @(negedge clk_sys);
        pulse_start();
        wait_ptr_ok("t6_ptr_ok");
        check("t6_len", 32'(upload_len), 32'd6);
        ss_set(1'b0);
        expect_byte("t6_r0", 8'h01);
        expect_byte("t6_r1", 8'h10);
        expect_byte("t6_r2", 8'hAA);
        expect_byte("t6_r3", 8'hBB);
        expect_byte("t6_r4", 8'hCC);
        expect_byte("t6_r5", 8'hDD);
        wait_idle("t6_busy_lo");
        ss_set(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
